// File: rtl/pgu_seq_pkg.sv
// Shared types and constants for the pgu segment sequencer.
//   seg_t   : one queued motion segment (dir, t_on, t_off, n_steps)
//   state_t : sequencer FSM states
//   T_MIN   : smallest legal t_on/t_off presented to the pgu
package pgu_seq_pkg;

  localparam int unsigned STEP_W = 32;
  localparam logic [31:0] T_MIN  = 32'd1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  typedef struct packed {
    logic              dir;
    logic [31:0]       t_on;
    logic [31:0]       t_off;
    logic [STEP_W-1:0] n_steps;
  } seg_t;

  // A zero phase time would stall the pgu, so it is raised to T_MIN.
  function automatic logic [31:0] clamp_t(input logic [31:0] t);
    return (t == '0) ? T_MIN : t;
  endfunction

endpackage

// File: rtl/pgu_sequencer_if.sv
// Segment push bus (valid/ready handshake plus segment payload).
//   master : segment source, drives valid and payload, receives ready
//   slave  : sequencer side, receives valid and payload, drives ready
interface pgu_sequencer_if #(
  parameter int unsigned STEP_W = 32
);
  logic              seg_valid;
  logic              seg_ready;
  logic              seg_dir;
  logic [31:0]       seg_t_on;
  logic [31:0]       seg_t_off;
  logic [STEP_W-1:0] seg_n_steps;

  modport master (
    output seg_valid, seg_dir, seg_t_on, seg_t_off, seg_n_steps,
    input  seg_ready
  );

  modport slave (
    input  seg_valid, seg_dir, seg_t_on, seg_t_off, seg_n_steps,
    output seg_ready
  );
endinterface

// File: rtl/pgu_sequencer_seg_fifo.sv
// Synchronous segment FIFO, DEPTH entries of seg_t (DEPTH a power of 2, >= 2).
//   clk, rst : clock, synchronous active-high reset
//   push/din : write din when not full
//   pop      : discard head when not empty
//   flush    : empty the FIFO (wins over push/pop)
//   full, empty, level : occupancy
//   head     : oldest entry (valid when !empty)
module seg_fifo
  import pgu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  seg_t                     din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output seg_t                     head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [AW:0] FULL_LVL = LW'(DEPTH);

  seg_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pgu_sequencer.sv
// Motion-segment scheduler in front of the pgu step/dir pulse generator.
// Segments are queued in a FIFO, loaded into the pgu one at a time, and
// their step pulses counted; the pgu step output is gated off whenever no
// segment is running.
//   clk, rst       : clock, synchronous active-high reset
//   seg            : segment push bus (slave side)
//   abort          : flush the queue and stop motion at the next edge
//   pgu_update     : one-cycle load strobe to the pgu
//   pgu_dir/t_on/t_off : segment parameters presented to the pgu
//   pgu_step       : free-running step from the pgu
//   step, dir      : gated step and direction to the motor driver
//   busy           : a segment is loaded or running
//   seg_done       : one-cycle pulse per completed segment
//   fifo_level     : queued segment count
module pgu_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned STEP_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  pgu_sequencer_if.slave         seg,
  input  logic                   abort,
  output logic                   pgu_update,
  output logic                   pgu_dir,
  output logic [31:0]            pgu_t_on,
  output logic [31:0]            pgu_t_off,
  input  logic                   pgu_step,
  output logic                   step,
  output logic                   dir,
  output logic                   busy,
  output logic                   seg_done,
  output logic [$clog2(DEPTH):0] fifo_level
);

  import pgu_seq_pkg::*;

  state_t            state;
  state_t            state_n;
  seg_t              seg_in;
  seg_t              fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [STEP_W-1:0] n_q;
  logic [STEP_W-1:0] cnt;
  logic              step_prev;
  logic              run_q;
  logic              rise;
  logic              fall;
  logic              complete;

  // No full-FIFO bypass: a pop in the same cycle does not open ready.
  assign seg.seg_ready = !fifo_full && !abort;
  assign push          = seg.seg_valid && seg.seg_ready;

  always_comb begin
    seg_in         = '0;
    seg_in.dir     = seg.seg_dir;
    seg_in.t_on    = seg.seg_t_on;
    seg_in.t_off   = seg.seg_t_off;
    seg_in.n_steps = seg.seg_n_steps;
  end

  seg_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .din   (seg_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level),
    .head  (fifo_head)
  );

  assign rise     = pgu_step && !step_prev;
  assign fall     = !pgu_step && step_prev;
  // Waiting for the falling edge keeps the last pulse's high time intact.
  assign complete = (state == RUN) && (cnt == n_q) && fall;

  assign step = pgu_step && run_q;
  assign dir  = pgu_dir;
  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        state_n = (n_q == '0) ? IDLE : RUN;
      end
      RUN: begin
        if (complete) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = LOAD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pgu_update <= 1'b0;
      pgu_dir    <= 1'b0;
      pgu_t_on   <= T_MIN;
      pgu_t_off  <= T_MIN;
      n_q        <= '0;
      cnt        <= '0;
      step_prev  <= 1'b0;
      run_q      <= 1'b0;
      seg_done   <= 1'b0;
    end else begin
      state      <= state_n;
      pgu_update <= 1'b0;
      seg_done   <= 1'b0;
      run_q      <= (state_n == RUN);
      step_prev  <= (state == LOAD) ? 1'b0 : pgu_step;

      // The head is captured on the pop edge, so the new dir is already
      // visible during LOAD while step is forced low.
      if (pop) begin
        pgu_dir   <= fifo_head.dir;
        pgu_t_on  <= clamp_t(fifo_head.t_on);
        pgu_t_off <= clamp_t(fifo_head.t_off);
        n_q       <= fifo_head.n_steps;
      end

      if (abort) begin
        cnt <= '0;
      end else begin
        unique case (state)
          LOAD: begin
            cnt        <= '0;
            pgu_update <= (n_q != '0);
            seg_done   <= (n_q == '0);
          end
          RUN: begin
            if (rise)     cnt      <= cnt + STEP_W'(1);
            if (complete) seg_done <= 1'b1;
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule
